// File: rtl/cpu_flags_pkg.sv
// Shared SM83 flag definitions: bit positions in {Z,N,H,C}, branch condition
// encodings, standard ALU write masks and the condition-result FSM states.
package cpu_flags_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] COND_NZ = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_NC = 2'b10;
  localparam logic [1:0] COND_C  = 2'b11;

  localparam logic [3:0] MASK_ALL    = 4'b1111;
  localparam logic [3:0] MASK_INCDEC = 4'b1110;
  localparam logic [3:0] MASK_NONE   = 4'b0000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } cond_state_e;

endpackage

// File: rtl/flag_register_unit_cond_eval.sv
// Combinational branch-condition evaluator (NZ/Z/NC/C) over a {Z,N,H,C} nibble;
// kept standalone so branch-target logic can share it.
module cond_eval
  import cpu_flags_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [1:0] cond,
  output logic       taken
);

  logic unused_nh;
  assign unused_nh = flags[FLAG_N] ^ flags[FLAG_H];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NZ: taken = ~flags[FLAG_Z];
      COND_Z:  taken =  flags[FLAG_Z];
      COND_NC: taken = ~flags[FLAG_C];
      COND_C:  taken =  flags[FLAG_C];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_register_unit.sv
// SM83 F register with prioritised bus/ALU/CCF/SCF writes and a one-cycle
// registered branch-condition result evaluated on the flags being committed.
module flag_register_unit
  import cpu_flags_pkg::*;
#(
  parameter logic [3:0] P_RESET_F = 4'b0000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_ALU_F,
  input  logic [3:0] i_ALU_Mask,
  input  logic       i_ALU_We,
  input  logic [7:0] i_Bus_D,
  input  logic       i_Bus_We,
  input  logic       i_SCF,
  input  logic       i_CCF,
  input  logic [1:0] i_Cond,
  input  logic       i_Cond_Req,
  output logic [3:0] o_F,
  output logic [7:0] o_F_Byte,
  output logic       o_Cond_Valid,
  output logic       o_Cond_Taken
);

  logic [3:0]  f_reg;
  logic [3:0]  f_next;
  logic [3:0]  alu_merged;
  logic        taken_next;
  logic        taken_reg;
  cond_state_e state_reg;

  // The low nibble of F always reads as zero, so the bus low bits are dropped.
  logic unused_bus_low;
  assign unused_bus_low = ^i_Bus_D[3:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign alu_merged[gi] = i_ALU_Mask[gi] ? i_ALU_F[gi] : f_reg[gi];
    end
  endgenerate

  // Single winner per cycle; lower-priority writes are discarded, not merged.
  always_comb begin
    f_next = f_reg;
    if (i_Bus_We) begin
      f_next = i_Bus_D[7:4];
    end else if (i_ALU_We) begin
      f_next = alu_merged;
    end else if (i_CCF) begin
      f_next[FLAG_N] = 1'b0;
      f_next[FLAG_H] = 1'b0;
      f_next[FLAG_C] = ~f_reg[FLAG_C];
    end else if (i_SCF) begin
      f_next[FLAG_N] = 1'b0;
      f_next[FLAG_H] = 1'b0;
      f_next[FLAG_C] = 1'b1;
    end
  end

  // Evaluating on f_next lets a branch see flags written in the same cycle.
  cond_eval u_cond_eval (
    .flags (f_next),
    .cond  (i_Cond),
    .taken (taken_next)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      f_reg     <= P_RESET_F;
      state_reg <= ST_IDLE;
      taken_reg <= 1'b0;
    end else begin
      f_reg <= f_next;
      case (state_reg)
        ST_IDLE, ST_RESULT: begin
          if (i_Cond_Req) begin
            state_reg <= ST_RESULT;
            taken_reg <= taken_next;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_F          = f_reg;
  assign o_F_Byte     = {f_reg, 4'b0000};
  assign o_Cond_Valid = (state_reg == ST_RESULT);
  assign o_Cond_Taken = taken_reg;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed and randomized checks of flag_register_unit against a bench-side
// flag model (separate z/n/h/c bits, priority chain, condition table).
module tb_flag_register_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_f, alu_mask;
  logic       alu_we;
  logic [7:0] bus_d;
  logic       bus_we, scf, ccf;
  logic [1:0] cond;
  logic       cond_req;
  logic [3:0] f;
  logic [7:0] f_byte;
  logic       cond_valid, cond_taken;

  int n_cmp = 0;
  int n_bad = 0;

  flag_register_unit #(.P_RESET_F(4'b0000)) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_ALU_F      (alu_f),
    .i_ALU_Mask   (alu_mask),
    .i_ALU_We     (alu_we),
    .i_Bus_D      (bus_d),
    .i_Bus_We     (bus_we),
    .i_SCF        (scf),
    .i_CCF        (ccf),
    .i_Cond       (cond),
    .i_Cond_Req   (cond_req),
    .o_F          (f),
    .o_F_Byte     (f_byte),
    .o_Cond_Valid (cond_valid),
    .o_Cond_Taken (cond_taken)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rst = 1'b0; alu_f = 4'h0; alu_mask = 4'h0; alu_we = 1'b0;
    bus_d = 8'h00; bus_we = 1'b0; scf = 1'b0; ccf = 1'b0;
    cond = 2'b00; cond_req = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_f(input logic [3:0] v);
    clear_inputs();
    bus_we = 1'b1; bus_d = {v, 4'h5};
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; bus_we = 1'b1; bus_d = 8'hFF; cond_req = 1'b1; scf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b0000 || f_byte !== 8'h00 || cond_valid !== 1'b0 || cond_taken !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: F=%b byte=%h valid=%b taken=%b, want 0000 00 0 0",
               f, f_byte, cond_valid, cond_taken);
    end
  endtask

  task automatic test_bus_load();
    clear_inputs();
    bus_we = 1'b1; bus_d = 8'hB7;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b1011 || f_byte !== 8'hB0) begin
      n_bad++;
      $display("FAIL bus_load: F=%b byte=%h, want 1011 b0", f, f_byte);
    end
  endtask

  task automatic test_incdec();
    load_f(4'b0001);
    alu_we = 1'b1; alu_f = 4'b1110; alu_mask = 4'b1110;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b1111) begin
      n_bad++;
      $display("FAIL incdec_keep_c: F=%b, want 1111", f);
    end
    alu_we = 1'b1; alu_f = 4'b0000; alu_mask = 4'b0000;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b1111) begin
      n_bad++;
      $display("FAIL mask_none: F=%b, want 1111", f);
    end
  endtask

  task automatic test_bypass();
    load_f(4'b0000);
    alu_we = 1'b1; alu_f = 4'b1000; alu_mask = 4'b1111;
    cond_req = 1'b1; cond = 2'b01;
    tick();
    clear_inputs();
    n_cmp++;
    if (cond_valid !== 1'b1 || cond_taken !== 1'b1 || f !== 4'b1000) begin
      n_bad++;
      $display("FAIL bypass: valid=%b taken=%b F=%b, want 1 1 1000", cond_valid, cond_taken, f);
    end
    tick();
    n_cmp++;
    if (cond_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL valid_drop: valid=%b, want 0", cond_valid);
    end
  endtask

  task automatic test_priority();
    load_f(4'b0110);
    bus_we = 1'b1; bus_d = 8'h00; alu_we = 1'b1; alu_f = 4'b1111; alu_mask = 4'b1111; scf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b0000) begin
      n_bad++;
      $display("FAIL bus_priority: F=%b, want 0000", f);
    end
    ccf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b0001) begin
      n_bad++;
      $display("FAIL ccf: F=%b, want 0001", f);
    end
    scf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b0001) begin
      n_bad++;
      $display("FAIL scf: F=%b, want 0001", f);
    end
    load_f(4'b1110);
    alu_we = 1'b1; alu_f = 4'b0001; alu_mask = 4'b0001; ccf = 1'b1; scf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b1111) begin
      n_bad++;
      $display("FAIL alu_over_ccf: F=%b, want 1111", f);
    end
    ccf = 1'b1; scf = 1'b1;
    tick();
    clear_inputs();
    n_cmp++;
    if (f !== 4'b1000) begin
      n_bad++;
      $display("FAIL ccf_over_scf: F=%b, want 1000", f);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] conds [4];
    logic       want  [4];
    conds = '{2'b10, 2'b11, 2'b00, 2'b01};
    want  = '{1'b0, 1'b1, 1'b1, 1'b0};
    load_f(4'b0001);
    for (int i = 0; i < 4; i++) begin
      cond_req = 1'b1; cond = conds[i];
      tick();
      n_cmp++;
      if (cond_valid !== 1'b1 || cond_taken !== want[i]) begin
        n_bad++;
        $display("FAIL b2b_%0d: valid=%b taken=%b, want 1 %b", i, cond_valid, cond_taken, want[i]);
      end
    end
    clear_inputs();
    tick();
    n_cmp++;
    if (cond_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: valid=%b, want 0", cond_valid);
    end
  endtask

  task automatic test_reset_drop();
    load_f(4'b1111);
    cond_req = 1'b1; cond = 2'b11;
    tick();
    clear_inputs();
    rst = 1'b1;
    n_cmp++;
    if (cond_valid !== 1'b1 || cond_taken !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_valid: valid=%b taken=%b, want 1 1", cond_valid, cond_taken);
    end
    tick();
    clear_inputs();
    n_cmp++;
    if (cond_valid !== 1'b0 || f !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_drop: valid=%b F=%b, want 0 0000", cond_valid, f);
    end
    load_f(4'b1111);
    rst = 1'b1; cond_req = 1'b1; cond = 2'b01;
    tick();
    clear_inputs();
    n_cmp++;
    if (cond_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL req_with_reset: valid=%b, want 0", cond_valid);
    end
  endtask

  task automatic test_random();
    bit m_z, m_n, m_h, m_c, m_valid, m_taken;
    bit nz, nn, nh, nc;
    clear_inputs();
    rst = 1'b1;
    tick();
    {m_z, m_n, m_h, m_c} = 4'b0000;
    m_valid = 0; m_taken = 0;
    for (int it = 0; it < 400; it++) begin
      rst      = ($urandom_range(0, 31) == 0);
      bus_we   = ($urandom_range(0, 5) == 0);
      bus_d    = 8'($urandom);
      alu_we   = ($urandom_range(0, 2) == 0);
      alu_f    = 4'($urandom);
      alu_mask = 4'($urandom);
      ccf      = ($urandom_range(0, 3) == 0);
      scf      = ($urandom_range(0, 3) == 0);
      cond     = 2'($urandom);
      cond_req = ($urandom_range(0, 1) == 1);
      // Model: pick the single highest-priority write, then evaluate the branch.
      {nz, nn, nh, nc} = {m_z, m_n, m_h, m_c};
      if (bus_we) begin
        {nz, nn, nh, nc} = bus_d[7:4];
      end else if (alu_we) begin
        if (alu_mask[3]) nz = alu_f[3];
        if (alu_mask[2]) nn = alu_f[2];
        if (alu_mask[1]) nh = alu_f[1];
        if (alu_mask[0]) nc = alu_f[0];
      end else if (ccf) begin
        nn = 0; nh = 0; nc = !m_c;
      end else if (scf) begin
        nn = 0; nh = 0; nc = 1;
      end
      if (rst) begin
        {m_z, m_n, m_h, m_c} = 4'b0000;
        m_valid = 0; m_taken = 0;
      end else begin
        {m_z, m_n, m_h, m_c} = {nz, nn, nh, nc};
        m_valid = cond_req;
        if (cond_req) begin
          case (cond)
            2'd0: m_taken = !nz;
            2'd1: m_taken = nz;
            2'd2: m_taken = !nc;
            default: m_taken = nc;
          endcase
        end
      end
      tick();
      n_cmp++;
      if (f !== {m_z, m_n, m_h, m_c} || f_byte !== {m_z, m_n, m_h, m_c, 4'b0000} ||
          cond_valid !== m_valid || (m_valid && cond_taken !== m_taken)) begin
        n_bad++;
        $display("FAIL random_%0d: F=%b byte=%h valid=%b taken=%b, want %b %h %b %b",
                 it, f, f_byte, cond_valid, cond_taken, {m_z, m_n, m_h, m_c},
                 {m_z, m_n, m_h, m_c, 4'b0000}, m_valid, m_taken);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_bus_load();
    test_incdec();
    test_bypass();
    test_priority();
    test_back_to_back();
    test_reset_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
